// File: rtl/mod_n_state_pkg.sv
// Shared types and helpers for the modulo-N state counter.
// Holds the count-direction encoding and the binary-to-Gray helper.
package mod_n_state_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Callers pass a zero-extended value and truncate the result to their own width.
    // That is safe because Gray bit i depends only on binary bits i and i+1.
    function automatic logic [31:0] bin2gray(input logic [31:0] value);
        return value ^ (value >> 1);
    endfunction

endpackage

// File: rtl/mod_n_next_state.sv
// Combinational successor logic for the modulo-N counter.
// Computes the next state and a wrap flag for one step in the requested direction.
module mod_n_next_state
    import mod_n_state_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic [WIDTH-1:0] curr_state,
    input  dir_e             dir,
    output logic [WIDTH-1:0] next_state,
    output logic             wrap
);

    localparam int               MAX_V     = MODULUS - 1;
    localparam logic [WIDTH-1:0] MAX_STATE = WIDTH'(MAX_V);

    // Compare in 32 bits so that MODULUS == 2**WIDTH needs no special case.
    logic [31:0] cur_ext;
    assign cur_ext = 32'(curr_state);

    always_comb begin
        next_state = curr_state;
        wrap       = 1'b0;
        if (dir == DIR_UP) begin
            if (cur_ext >= 32'(MAX_V)) begin
                next_state = '0;
                wrap       = 1'b1;
            end else begin
                next_state = curr_state + WIDTH'(1);
            end
        end else begin
            // An out-of-range value is recovered to the top of the range and counts as a wrap.
            if ((curr_state == '0) || (cur_ext >= 32'(MODULUS))) begin
                next_state = MAX_STATE;
                wrap       = 1'b1;
            end else begin
                next_state = curr_state - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mod_n_state_counter.sv
// Up/down modulo-N state counter with range-checked load, a terminal-count pulse and a saturating wrap count.
// Optional registered Gray-coded output when GRAY_OUT_EN is defined.
module mod_n_state_counter
    import mod_n_state_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic              dir,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  curr_state,
    output logic              tc,
    output logic              load_err,
    output logic [WRAP_W-1:0] wrap_cnt
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0]  gray_state
`endif
);

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $error("mod_n_state_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    logic [WIDTH-1:0]  state_q, state_d;
    logic              tc_q, tc_d;
    logic              err_q, err_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [WIDTH-1:0]  step_state;
    logic              step_wrap;
    logic              load_ok;

    mod_n_next_state #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_next (
        .curr_state(state_q),
        .dir       (dir_e'(dir)),
        .next_state(step_state),
        .wrap      (step_wrap)
    );

    assign load_ok = (32'(load_val) < 32'(MODULUS));

    // Load beats a step, so a load never pulses tc or moves the wrap count.
    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        wrap_d  = wrap_q;
        if (load) begin
            if (load_ok) begin
                state_d = load_val;
            end else begin
                state_d = '0;
                err_d   = 1'b1;
            end
        end else if (w) begin
            state_d = step_state;
            if (step_wrap) begin
                tc_d = 1'b1;
                if (wrap_q != '1) begin
                    wrap_d = wrap_q + WRAP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign curr_state = state_q;
    assign tc         = tc_q;
    assign load_err   = err_q;
    assign wrap_cnt   = wrap_q;

`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    // Encoding the next state keeps gray_state aligned with curr_state on every edge.
    assign gray_d = WIDTH'(bin2gray(32'(state_d)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray_state = gray_q;
`endif

endmodule
